pc_fetch: RTL and testbench



---
 rtl/pc_fetch.sv | 76 +++++++
 tb/tb_pc_fetch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch
// Description : Fetch-stage PC register and F-side bundle builder feeding the
//               F/D pipeline register (redirect, ERET, AdEL detection).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    input  logic        D_jump,
    input  logic        D_taken,
    input  logic [31:0] D_target,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_Ins,
    output logic [31:0] F_PCAddr,
    output logic [31:0] F_PCPlus4,
    output logic [4:0]  F_ExcCode,
    output logic        F_BD
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic        w_adel;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_adel     = (r_pc[1:0] != 2'b00) || (r_pc < IM_LO) || (r_pc > IM_HI);

    // req outranks stall so the PC and the F/D nop injection land on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (req) begin
            r_pc <= HANDLER_PC;
        end else if (!stall) begin
            if (D_eret) begin
                r_pc <= EPC;
            end else if (D_jump && D_taken) begin
                r_pc <= D_target;
            end else begin
                r_pc <= w_pc_plus4;
            end
        end
    end

    // ERET has no delay slot: the wrong-path fetch becomes a nop and never faults
    always_comb begin
        F_Ins     = i_inst_rdata;
        F_ExcCode = 5'd0;
        if (D_eret) begin
            F_Ins     = 32'd0;
            F_ExcCode = 5'd0;
        end else if (w_adel) begin
            F_Ins     = 32'd0;
            F_ExcCode = EXC_ADEL;
        end
    end

    assign i_inst_addr = r_pc;
    assign F_PCAddr    = r_pc;
    assign F_PCPlus4   = w_pc_plus4;
    assign F_BD        = D_jump;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch
// Description : Directed scoreboard bench for pc_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        req;
    logic        D_eret;
    logic [31:0] EPC;
    logic        D_jump;
    logic        D_taken;
    logic [31:0] D_target;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] F_Ins;
    logic [31:0] F_PCAddr;
    logic [31:0] F_PCPlus4;
    logic [4:0]  F_ExcCode;
    logic        F_BD;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] plus4;
        logic [31:0] ins;
        logic [4:0]  exc;
        logic        bd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;

    pc_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .req          (req),
        .D_eret       (D_eret),
        .EPC          (EPC),
        .D_jump       (D_jump),
        .D_taken      (D_taken),
        .D_target     (D_target),
        .i_inst_addr  (i_inst_addr),
        .i_inst_rdata (i_inst_rdata),
        .F_Ins        (F_Ins),
        .F_PCAddr     (F_PCAddr),
        .F_PCPlus4    (F_PCPlus4),
        .F_ExcCode    (F_ExcCode),
        .F_BD         (F_BD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: a distinct word per address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign i_inst_rdata = mem(i_inst_addr);

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, score the combinational bundle, advance the model PC
    task automatic step(input string tag, input logic rst, input logic rq, input logic st,
                        input logic er, input logic [31:0] epc_v, input logic jp,
                        input logic tk, input logic [31:0] tgt);
        exp_t e;
        exp_t got;
        logic adel;
        @(negedge clk);
        reset = rst; req = rq; stall = st; D_eret = er; EPC = epc_v;
        D_jump = jp; D_taken = tk; D_target = tgt;
        adel    = (m_pc[1:0] != 2'b00) || (m_pc < 32'h3000) || (m_pc > 32'h6FFC);
        e.pc    = m_pc;
        e.plus4 = m_pc + 32'd4;
        e.ins   = (er || adel) ? 32'd0 : mem(m_pc);
        e.exc   = (!er && adel) ? 5'd4 : 5'd0;
        e.bd    = jp;
        sb.push_back(e);
        #2;
        got = sb.pop_front();
        chk({tag, ".addr"},  i_inst_addr, got.pc);
        chk({tag, ".pc"},    F_PCAddr,    got.pc);
        chk({tag, ".plus4"}, F_PCPlus4,   got.plus4);
        chk({tag, ".ins"},   F_Ins,       got.ins);
        chk({tag, ".exc"},   {27'd0, F_ExcCode}, {27'd0, got.exc});
        chk({tag, ".bd"},    {31'd0, F_BD},      {31'd0, got.bd});
        if (rst)          m_pc = 32'h3000;
        else if (rq)      m_pc = 32'h4180;
        else if (st)      m_pc = m_pc;
        else if (er)      m_pc = epc_v;
        else if (jp && tk) m_pc = tgt;
        else              m_pc = m_pc + 32'd4;
    endtask

    task automatic nop(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic jmp(input string tag, input logic [31:0] tgt);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, tgt);
    endtask

    task automatic pc_is(input string tag, input logic [31:0] exp);
        @(negedge clk);
        #1;
        chk(tag, F_PCAddr, exp);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; req = 1'b0; D_eret = 1'b0; EPC = '0;
        D_jump = 1'b0; D_taken = 1'b0; D_target = '0;
        repeat (2) @(posedge clk);
        m_pc = 32'h3000;
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("reset_pc_const", F_PCAddr, 32'h0000_3000);
        chk("reset_plus4_const", F_PCPlus4, 32'h0000_3004);

        nop("free0");
        nop("free1");
        chk("free1_const", F_PCAddr, 32'h0000_3004);
        nop("free2");
        chk("free2_const", F_PCAddr, 32'h0000_3008);
        nop("free3");
        jmp("ds_3010", 32'h3400);
        chk("ds_3010_bd", {31'd0, F_BD}, 32'd1);
        jmp("at_3400", 32'h3020);
        chk("at_3400_const", F_PCAddr, 32'h0000_3400);

        step("stall0", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h3100);
        step("stall1", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h3100);
        chk("stall1_const", F_PCAddr, 32'h0000_3020);
        jmp("unstall", 32'h3100);
        jmp("at_3100", 32'h3002);
        chk("at_3100_const", F_PCAddr, 32'h0000_3100);

        jmp("mis_3002", 32'h7000);
        chk("mis_exc_const", {27'd0, F_ExcCode}, 32'd4);
        chk("mis_ins_const", F_Ins, 32'd0);
        step("eret_7000", 1'b0, 1'b0, 1'b0, 1'b1, 32'h3060, 1'b0, 1'b0, 32'd0);
        chk("eret_exc_const", {27'd0, F_ExcCode}, 32'd0);
        jmp("at_3060", 32'h3050);
        chk("at_3060_const", F_PCAddr, 32'h0000_3060);
        step("req_stall", 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        step("eret_stall", 1'b0, 1'b0, 1'b1, 1'b1, 32'h3200, 1'b0, 1'b0, 32'd0);
        chk("handler_const", F_PCAddr, 32'h0000_4180);
        step("req_eret", 1'b0, 1'b1, 1'b0, 1'b1, 32'h3200, 1'b0, 1'b0, 32'd0);
        jmp("at_handler", 32'h6FFC);

        jmp("at_hi", 32'h2FFC);
        chk("at_hi_exc_const", {27'd0, F_ExcCode}, 32'd0);
        jmp("below_lo", 32'hFFFF_FFFC);
        nop("top");
        nop("wrapped");
        chk("wrapped_const", F_PCAddr, 32'h0000_0000);
        step("reset_mid", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h5000);
        nop("after_reset");
        chk("after_reset_const", F_PCAddr, 32'h0000_3000);
        pc_is("after_reset_next", 32'h0000_3004);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
